// File: rtl/can_clic_seq_pkg.sv
// Shared defaults and source-table types for the clocked CAN-CLIC interrupt controller.
package can_clic_seq_pkg;

  localparam int unsigned DEF_NR_INDEX_BITS = 4;
  localparam int unsigned DEF_NR_PRIO_BITS  = 3;
  localparam int unsigned DEF_NR_SRC        = 2 ** DEF_NR_INDEX_BITS;

  typedef logic [DEF_NR_INDEX_BITS-1:0] index_t;
  typedef logic [DEF_NR_PRIO_BITS-1:0]  prio_t;

  typedef struct packed {
    logic  enable;
    logic  pending;
    prio_t prio;
  } entry_t;

  typedef entry_t [DEF_NR_SRC-1:0] entries_t;

endpackage

// File: rtl/can_clic_seq_arb.sv
// Combinational bit-serial elimination: highest priority wins, ties go to the highest index.
module can_clic_seq_arb
  import can_clic_seq_pkg::*;
#(
  parameter int unsigned NR_INDEX_BITS = DEF_NR_INDEX_BITS,
  parameter int unsigned NR_PRIO_BITS  = DEF_NR_PRIO_BITS,
  localparam int unsigned N            = 2 ** NR_INDEX_BITS
) (
  input  logic [N-1:0]                   cand_i,
  input  logic [N-1:0][NR_PRIO_BITS-1:0] prio_i,
  output logic                           found_o,
  output logic [NR_INDEX_BITS-1:0]       win_index_o,
  output logic [NR_PRIO_BITS-1:0]        win_prio_o
);

  logic [N-1:0] alive;
  logic [N-1:0] keep;

  always_comb begin
    // NOTE: every variable gets a value before any branch, so no latch can be inferred.
    alive       = cand_i;
    keep        = '0;
    win_index_o = '0;
    win_prio_o  = '0;

    // A bit position only eliminates sources when at least one survivor has that bit set.
    for (int b = int'(NR_PRIO_BITS) - 1; b >= 0; b--) begin
      for (int i = 0; i < int'(N); i++) keep[i] = alive[i] & prio_i[i][b];
      if (|keep) alive = keep;
    end

    for (int b = int'(NR_INDEX_BITS) - 1; b >= 0; b--) begin
      for (int i = 0; i < int'(N); i++) keep[i] = alive[i] && (((i >> b) & 1) != 0);
      if (|keep) alive = keep;
    end

    found_o = |cand_i;
    for (int i = 0; i < int'(N); i++) begin
      if (alive[i]) begin
        win_index_o = NR_INDEX_BITS'(i);
        win_prio_o  = prio_i[i];
      end
    end
  end

endmodule

// File: rtl/can_clic_seq.sv
// Clocked CAN-CLIC: per-source enable/pending/priority, edge-latched requests,
// registered threshold-masked winner and a claim handshake that retires it.
module can_clic_seq
  import can_clic_seq_pkg::*;
#(
  parameter int unsigned NR_INDEX_BITS = DEF_NR_INDEX_BITS,
  parameter int unsigned NR_PRIO_BITS  = DEF_NR_PRIO_BITS,
  localparam int unsigned N            = 2 ** NR_INDEX_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N-1:0]             irq,
  input  logic                     cfg_we,
  input  logic [NR_INDEX_BITS-1:0] cfg_index,
  input  logic                     cfg_enable,
  input  logic [NR_PRIO_BITS-1:0]  cfg_prio,
  input  logic                     cfg_set_pend,
  input  logic [NR_PRIO_BITS-1:0]  threshold,
  input  logic                     claim,
  input  logic [NR_INDEX_BITS-1:0] claim_index,
  output logic                     is_interrupt,
  output logic [NR_INDEX_BITS-1:0] index,
  output logic [NR_PRIO_BITS-1:0]  prio,
  output logic                     claim_error
);

  typedef struct packed {
    logic                    enable;
    logic                    pending;
    logic [NR_PRIO_BITS-1:0] prio;
  } src_t;

  src_t [N-1:0] src_q, src_d;
  logic [N-1:0] irq_q;
  logic [N-1:0] pend_set;
  logic [N-1:0] cand;
  logic [N-1:0][NR_PRIO_BITS-1:0] prio_vec;

  logic                     found;
  logic [NR_INDEX_BITS-1:0] win_index;
  logic [NR_PRIO_BITS-1:0]  win_prio;

  logic                     is_int_q, is_int_d;
  logic [NR_INDEX_BITS-1:0] index_q, index_d;
  logic [NR_PRIO_BITS-1:0]  prio_q, prio_d;
  logic                     claim_err_q, claim_err_d;
  logic                     claim_ok;

  assign pend_set = irq & ~irq_q;
  assign claim_ok = claim & is_int_q & (claim_index == index_q);

  always_comb begin
    cand     = '0;
    prio_vec = '0;
    for (int i = 0; i < int'(N); i++) begin
      cand[i]     = src_q[i].pending & src_q[i].enable & (src_q[i].prio > threshold);
      prio_vec[i] = src_q[i].prio;
    end
  end

  // Sets are applied after the claim clear so a same-cycle request is never lost.
  always_comb begin
    src_d = src_q;
    if (claim_ok) src_d[index_q].pending = 1'b0;
    if (cfg_we) begin
      src_d[cfg_index].enable = cfg_enable;
      src_d[cfg_index].prio   = cfg_prio;
      if (cfg_set_pend) src_d[cfg_index].pending = 1'b1;
    end
    for (int i = 0; i < int'(N); i++) begin
      if (pend_set[i]) src_d[i].pending = 1'b1;
    end
  end

  can_clic_seq_arb #(
    .NR_INDEX_BITS (NR_INDEX_BITS),
    .NR_PRIO_BITS  (NR_PRIO_BITS)
  ) u_arb (
    .cand_i      (cand),
    .prio_i      (prio_vec),
    .found_o     (found),
    .win_index_o (win_index),
    .win_prio_o  (win_prio)
  );

  // The just-claimed winner is still in the table this cycle, so suppress the offer once.
  assign is_int_d    = found & ~claim_ok;
  assign index_d     = is_int_d ? win_index : '0;
  assign prio_d      = is_int_d ? win_prio  : '0;
  assign claim_err_d = claim & ~claim_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the source table is control state, not bulk storage, so it is reset with the rest.
      src_q       <= '0;
      irq_q       <= '0;
      is_int_q    <= 1'b0;
      index_q     <= '0;
      prio_q      <= '0;
      claim_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      src_q       <= src_d;
      irq_q       <= irq;
      is_int_q    <= is_int_d;
      index_q     <= index_d;
      prio_q      <= prio_d;
      claim_err_q <= claim_err_d;
    end
  end

  assign is_interrupt = is_int_q;
  assign index        = index_q;
  assign prio         = prio_q;
  assign claim_error  = claim_err_q;

endmodule
